// File: rtl/nts_rx_fetch_pkg.sv
// Shared definitions for the NTS RX fetch engine: FSM state encodings,
// RX read size codes, the well-known destination channel indices and the
// tail byte-mask helper used by the lane packer.
package nts_rx_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // RX buffer read size codes
   localparam logic [2:0] WS_8  = 3'd0;
   localparam logic [2:0] WS_16 = 3'd1;
   localparam logic [2:0] WS_32 = 3'd2;
   localparam logic [2:0] WS_64 = 3'd3;

   // Destination regions consumed by the AES-SIV core
   localparam logic [2:0] CH_AD    = 3'd0;
   localparam logic [2:0] CH_NONCE = 3'd1;
   localparam logic [2:0] CH_TAG   = 3'd2;
   localparam logic [2:0] CH_PC    = 3'd3;

   // Byte b of a 64-bit read sits in [63-8b -: 8]; keep it only while
   // b is below the number of bytes still owed to the destination.
   function automatic logic [63:0] tail_mask64(input logic [9:0] rem);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < 8; b++) begin
         if (rem > 10'(b)) m[63-8*b -: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/nts_rx_fetch_packer.sv
// Lane packer: collects 64-bit RX reads into one RAM_WIDTH-bit word,
// MSB lane first, zeroing bytes past the remaining count.
// Ports: i_clr empties the word (start/after write), i_vld loads i_dat into
//   the next lane masked by i_rem; o_word is the word being built,
//   o_lane_last flags that the next load fills the final lane.
module nts_rx_fetch_packer
   import nts_rx_fetch_pkg::*;
#(
   parameter int RAM_WIDTH = 128
)(
   input  logic                 i_clk,
   input  logic                 i_areset,
   input  logic                 i_clr,
   input  logic                 i_vld,
   input  logic [63:0]          i_dat,
   input  logic [9:0]           i_rem,
   output logic [RAM_WIDTH-1:0] o_word,
   output logic                 o_lane_last
);

   localparam int LANES = RAM_WIDTH / 64;

   logic [RAM_WIDTH-1:0] word_q, word_d;
   logic [1:0]           lane_q, lane_d;

   always_comb begin
      word_d = word_q;
      lane_d = lane_q;
      if (i_clr) begin
         // clearing here is what makes unfilled tail lanes read as zero
         word_d = '0;
         lane_d = '0;
      end else if (i_vld) begin
         for (int l = 0; l < LANES; l++) begin
            if (lane_q == 2'(l)) word_d[RAM_WIDTH-1-64*l -: 64] = i_dat & tail_mask64(i_rem);
         end
         lane_d = lane_q + 2'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         word_q <= '0;
         lane_q <= '0;
      end else begin
         word_q <= word_d;
         lane_q <= lane_d;
      end
   end

   assign o_word      = word_q;
   assign o_lane_last = (lane_q == 2'(LANES - 1));

endmodule

// File: rtl/nts_rx_fetch_engine.sv
// RX-buffer-to-RAM copy engine: fetches a byte range with 64-bit reads,
// packs them into RAM_WIDTH-bit words (zero tail) and writes them into a
// channel region, recording the copied length per channel.
// Ports: i_start/i_channel/i_src_addr/i_bytes/i_dst_addr command;
//   o_busy/o_done/o_error/o_len status; o_rx_* / i_rx_* RX read port;
//   o_ram_* destination RAM write port.
// Optional: define NTS_RX_FETCH_TIMEOUT_EN for a WAIT-state watchdog.
module nts_rx_fetch_engine
   import nts_rx_fetch_pkg::*;
#(
   parameter int RX_PORT_WIDTH  = 64,
   parameter int ADDR_WIDTH     = 8,
   parameter int RAM_WIDTH      = 128,
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int CHANNELS       = 4,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                      i_clk,
   input  logic                      i_areset,
   input  logic                      i_start,
   input  logic [2:0]                i_channel,
   input  logic [ADDR_WIDTH+2:0]     i_src_addr,
   input  logic [9:0]                i_bytes,
   input  logic [RAM_ADDR_WIDTH-1:0] i_dst_addr,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_error,
   output logic [CHANNELS*10-1:0]    o_len,
   input  logic                      i_rx_wait,
   output logic [ADDR_WIDTH+2:0]     o_rx_addr,
   output logic [2:0]                o_rx_wordsize,
   output logic                      o_rx_rd_en,
   input  logic                      i_rx_rd_dv,
   input  logic [RX_PORT_WIDTH-1:0]  i_rx_rd_data,
   output logic                      o_ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
   output logic [RAM_WIDTH-1:0]      o_ram_wdata
);

   localparam int BAW      = ADDR_WIDTH + 3;
   localparam int BPW_LOG2 = (RAM_WIDTH == 128) ? 4 : 3;
   localparam int CW       = RAM_ADDR_WIDTH + 12;

   state_e                    state_q, state_d;
   logic [2:0]                ch_q, ch_d;
   logic [BAW-1:0]            rd_addr_q, rd_addr_d;
   logic [9:0]                bytes_q, bytes_d;
   logic [9:0]                rem_q, rem_d;
   logic [RAM_ADDR_WIDTH-1:0] dst_q, dst_d;
   logic                      err_q, err_d;
   logic                      last_q, last_d;
   logic [CHANNELS*10-1:0]    len_q, len_d;

   logic                      pk_clr, pk_vld, pk_lane_last;
   logic [RAM_WIDTH-1:0]      pk_word;
   logic [CW-1:0]             end_word;
   logic                      bad_req;
   logic                      rd_en;
   logic                      wd_hit;

`ifdef NTS_RX_FETCH_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] wd_q, wd_d;

   // counts consecutive WAIT cycles; restarts for every read
   always_comb begin
      wd_d = '0;
      if (state_q == ST_WAIT) wd_d = wd_q + WDW'(1);
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) wd_q <= '0;
      else          wd_q <= wd_d;
   end

   assign wd_hit = (state_q == ST_WAIT) && (32'(wd_q) >= 32'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign wd_hit         = 1'b0;
`endif

   // One past the last destination word the copy would touch; a copy
   // that would run past the top of the RAM is rejected instead of wrapping.
   always_comb begin
      end_word = CW'(dst_q) + ((CW'(bytes_q) + CW'((1 << BPW_LOG2) - 1)) >> BPW_LOG2);
      bad_req  = (bytes_q == 10'd0) || (32'(ch_q) >= 32'(CHANNELS)) ||
                 (end_word > CW'(1 << RAM_ADDR_WIDTH));
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      rd_addr_d = rd_addr_q;
      bytes_d   = bytes_q;
      rem_d     = rem_q;
      dst_d     = dst_q;
      err_d     = err_q;
      last_d    = last_q;
      len_d     = len_q;
      pk_clr    = 1'b0;
      pk_vld    = 1'b0;
      rd_en     = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // o_busy is already low in DONE, so a back-to-back start is taken
            if (i_start) begin
               state_d   = ST_CHECK;
               ch_d      = i_channel;
               rd_addr_d = i_src_addr;
               bytes_d   = i_bytes;
               rem_d     = i_bytes;
               dst_d     = i_dst_addr;
               err_d     = 1'b0;
               last_d    = 1'b0;
               pk_clr    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (bad_req) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!i_rx_wait) begin
               rd_en     = 1'b1;
               rd_addr_d = rd_addr_q + BAW'(8);
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_rx_rd_dv) begin
               pk_vld = 1'b1;
               rem_d  = (rem_q > 10'd8) ? rem_q - 10'd8 : 10'd0;
               if (rem_q <= 10'd8) last_d = 1'b1;
               state_d = (rem_q <= 10'd8 || pk_lane_last) ? ST_WRITE : ST_REQ;
            end else if (wd_hit) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WRITE: begin
            pk_clr = 1'b1;
            dst_d  = dst_q + RAM_ADDR_WIDTH'(1);
            if (last_q) begin
               state_d = ST_DONE;
               for (int c = 0; c < CHANNELS; c++) begin
                  if (32'(ch_q) == 32'(c)) len_d[c*10 +: 10] = bytes_q;
               end
            end else begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state_q   <= ST_IDLE;
         ch_q      <= '0;
         rd_addr_q <= '0;
         bytes_q   <= '0;
         rem_q     <= '0;
         dst_q     <= '0;
         err_q     <= 1'b0;
         last_q    <= 1'b0;
         len_q     <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         rd_addr_q <= rd_addr_d;
         bytes_q   <= bytes_d;
         rem_q     <= rem_d;
         dst_q     <= dst_d;
         err_q     <= err_d;
         last_q    <= last_d;
         len_q     <= len_d;
      end
   end

   nts_rx_fetch_packer #(
      .RAM_WIDTH (RAM_WIDTH)
   ) u_packer (
      .i_clk       (i_clk),
      .i_areset    (i_areset),
      .i_clr       (pk_clr),
      .i_vld       (pk_vld),
      .i_dat       (i_rx_rd_data),
      .i_rem       (rem_q),
      .o_word      (pk_word),
      .o_lane_last (pk_lane_last)
   );

   assign o_busy        = (state_q == ST_CHECK) || (state_q == ST_REQ) ||
                          (state_q == ST_WAIT)  || (state_q == ST_WRITE);
   assign o_done        = (state_q == ST_DONE);
   assign o_error       = err_q;
   assign o_len         = len_q;
   assign o_rx_addr     = rd_addr_q;
   assign o_rx_wordsize = WS_64;
   assign o_rx_rd_en    = rd_en;
   assign o_ram_we      = (state_q == ST_WRITE);
   assign o_ram_addr    = dst_q;
   assign o_ram_wdata   = pk_word;

endmodule

// File: tb/tb_nts_rx_fetch_engine.sv
// Bench for nts_rx_fetch_engine: table of copy commands with hand-computed
// read/write counts, an RX buffer responder and a RAM image, plus sequences
// for the watchdog and mid-copy reset.
module tb_nts_rx_fetch_engine;
   import nts_rx_fetch_pkg::*;

   localparam int TB_TIMEOUT = 255;

   logic         clk;
   logic         i_areset;
   logic         i_start;
   logic [2:0]   i_channel;
   logic [10:0]  i_src_addr;
   logic [9:0]   i_bytes;
   logic [7:0]   i_dst_addr;
   logic         o_busy, o_done, o_error;
   logic [39:0]  o_len;
   logic         i_rx_wait;
   logic [10:0]  o_rx_addr;
   logic [2:0]   o_rx_wordsize;
   logic         o_rx_rd_en;
   logic         i_rx_rd_dv;
   logic [63:0]  i_rx_rd_data;
   logic         o_ram_we;
   logic [7:0]   o_ram_addr;
   logic [127:0] o_ram_wdata;

   nts_rx_fetch_engine #(
      .RX_PORT_WIDTH (64), .ADDR_WIDTH (8), .RAM_WIDTH (128),
      .RAM_ADDR_WIDTH (8), .CHANNELS (4), .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .i_clk (clk), .i_areset (i_areset), .i_start (i_start),
      .i_channel (i_channel), .i_src_addr (i_src_addr), .i_bytes (i_bytes),
      .i_dst_addr (i_dst_addr), .o_busy (o_busy), .o_done (o_done),
      .o_error (o_error), .o_len (o_len), .i_rx_wait (i_rx_wait),
      .o_rx_addr (o_rx_addr), .o_rx_wordsize (o_rx_wordsize),
      .o_rx_rd_en (o_rx_rd_en), .i_rx_rd_dv (i_rx_rd_dv),
      .i_rx_rd_data (i_rx_rd_data), .o_ram_we (o_ram_we),
      .o_ram_addr (o_ram_addr), .o_ram_wdata (o_ram_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // responder configuration (written by the main sequence only)
   int cfg_lat      = 1;
   int cfg_wait     = 0;
   bit cfg_withhold = 1'b0;

   // responder/monitor state (written by the responder only)
   int           rd_count = 0;
   int           rd_viol  = 0;
   int           wr_count = 0;
   logic [127:0] ram_img [256];

   logic [39:0]  len_exp = '0;

   function automatic logic [7:0] mem_byte(input int a);
      return 8'((((a & 2047) * 37) + 11)) | 8'h01;
   endfunction

   function automatic logic [127:0] exp_word(input int src, input int nbytes, input int w);
      logic [127:0] r;
      int idx;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         idx = w * 16 + j;
         if (idx < nbytes) r[127-8*j -: 8] = mem_byte(src + idx);
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // RX buffer model: one read at a time, dv after cfg_lat cycles, then
   // i_rx_wait held for cfg_wait cycles. Also captures RAM writes.
   initial begin
      int  pend_cnt, pend_addr, wait_ctr;
      bit  busy_prev;
      pend_cnt = 0; pend_addr = 0; wait_ctr = 0; busy_prev = 1'b0;
      i_rx_rd_dv = 1'b0; i_rx_rd_data = '0; i_rx_wait = 1'b0;
      forever begin
         @(negedge clk);
         i_rx_rd_dv = 1'b0;
         if (i_areset) begin
            pend_cnt = 0;
            wait_ctr = 0;
         end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && !cfg_withhold) begin
               i_rx_rd_dv = 1'b1;
               for (int j = 0; j < 8; j++) i_rx_rd_data[63-8*j -: 8] = mem_byte(pend_addr + j);
               wait_ctr = cfg_wait;
            end
         end
         i_rx_wait = (wait_ctr > 0);
         if (wait_ctr > 0) wait_ctr--;
         #1;
         if (o_busy && !busy_prev) wait_ctr = cfg_wait;
         busy_prev = o_busy;
         if (o_rx_rd_en) begin
            rd_count++;
            if (i_rx_wait || pend_cnt > 0) rd_viol++;
            pend_addr = int'(o_rx_addr);
            pend_cnt  = cfg_lat;
         end
         if (o_ram_we) begin
            ram_img[o_ram_addr] = o_ram_wdata;
            wr_count++;
         end
      end
   end

   typedef struct {
      int ch; int src; int nbytes; int dst; int wt; int lat;
      int err; int reads; int writes; int poke;
   } vec_t;

   task automatic run_txn(input int id, input vec_t v);
      int  rb, wb, vb, cyc, bad;
      bit  got;
      cfg_wait = v.wt; cfg_lat = v.lat;
      rb = rd_count; wb = wr_count; vb = rd_viol;
      @(negedge clk); #2;
      i_channel = 3'(v.ch); i_src_addr = 11'(v.src); i_bytes = 10'(v.nbytes);
      i_dst_addr = 8'(v.dst); i_start = 1'b1;
      @(negedge clk); #2;
      i_start = 1'b0;
      cyc = 0; got = 1'b0;
      while (cyc < 5000 && !got) begin
         @(negedge clk); #2;
         cyc++;
         if (v.poke != 0 && cyc == 4) begin
            i_channel = 3'd7; i_bytes = 10'd0; i_start = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         if (o_done) got = 1'b1;
      end
      i_start = 1'b0;
      check($sformatf("v%0d.done", id), 64'(got), 64'd1);
      check($sformatf("v%0d.error", id), 64'(o_error), 64'(v.err));
      check($sformatf("v%0d.busy_at_done", id), 64'(o_busy), 64'd0);
      check($sformatf("v%0d.reads", id), 64'(rd_count - rb), 64'(v.reads));
      check($sformatf("v%0d.writes", id), 64'(wr_count - wb), 64'(v.writes));
      check($sformatf("v%0d.rd_protocol", id), 64'(rd_viol - vb), 64'd0);
      if (v.err != 0) check($sformatf("v%0d.err_latency", id), 64'(cyc <= 3), 64'd1);
      else len_exp[v.ch*10 +: 10] = 10'(v.nbytes);
      check($sformatf("v%0d.len", id), 64'(o_len), 64'(len_exp));
      if (v.err == 0) begin
         bad = 0;
         for (int w = 0; w < v.writes; w++) begin
            if (ram_img[(v.dst + w) & 255] !== exp_word(v.src, v.nbytes, w)) begin
               if (bad == 0)
                  $display("FAIL v%0d.word%0d: got 0x%032h, expected 0x%032h", id, w,
                           ram_img[(v.dst + w) & 255], exp_word(v.src, v.nbytes, w));
               bad++;
            end
         end
         check($sformatf("v%0d.data_bad_words", id), 64'(bad), 64'd0);
      end
      @(negedge clk); #2;
      check($sformatf("v%0d.done_pulse", id), 64'(o_done), 64'd0);
      check($sformatf("v%0d.error_held", id), 64'(o_error), 64'(v.err));
   endtask

   vec_t vecs[11];

   initial begin
      int cyc;
      bit got;
      i_areset = 1'b1; i_start = 1'b0; i_channel = '0; i_src_addr = '0;
      i_bytes = '0; i_dst_addr = '0;

      repeat (3) @(negedge clk);
      #2;
      check("rst.busy", 64'(o_busy), 64'd0);
      check("rst.done", 64'(o_done), 64'd0);
      check("rst.error", 64'(o_error), 64'd0);
      check("rst.len", 64'(o_len), 64'd0);
      check("rst.rd_en", 64'(o_rx_rd_en), 64'd0);
      check("rst.ram_we", 64'(o_ram_we), 64'd0);
      check("rst.ram_addr", 64'(o_ram_addr), 64'd0);
      check("rst.ram_wdata", 64'(o_ram_wdata[127:64] | o_ram_wdata[63:0]), 64'd0);
      check("rst.rx_addr", 64'(o_rx_addr), 64'd0);
      i_areset = 1'b0;
      @(negedge clk); #2;
      check("wordsize", 64'(o_rx_wordsize), 64'd3);

      //          ch        src     bytes dst   wt lat err rd  wr poke
      vecs[0]  = '{CH_AD,    'h080, 188, 'h00, 0, 1, 0,  24, 12, 0};
      vecs[1]  = '{CH_NONCE, 'h180, 16,  'h20, 0, 1, 0,  2,  1,  0};
      vecs[2]  = '{CH_AD,    'h000, 0,   'h00, 0, 1, 1,  0,  0,  0};
      vecs[3]  = '{7,        'h000, 16,  'h00, 0, 1, 1,  0,  0,  0};
      vecs[4]  = '{CH_AD,    'h080, 188, 'h40, 5, 3, 0,  24, 12, 0};
      vecs[5]  = '{CH_PC,    'h005, 9,   'hFF, 0, 2, 0,  2,  1,  0};
      vecs[6]  = '{CH_TAG,   'h000, 17,  'hFF, 0, 1, 1,  0,  0,  0};
      vecs[7]  = '{CH_TAG,   'h7F8, 8,   'h10, 0, 1, 0,  1,  1,  0};
      vecs[8]  = '{CH_PC,    'h000, 1023,'hC0, 0, 1, 0,  128,64, 0};
      vecs[9]  = '{4,        'h000, 8,   'h00, 0, 1, 1,  0,  0,  0};
      vecs[10] = '{CH_TAG,   'h100, 40,  'h30, 0, 1, 0,  5,  3,  1};
      for (int i = 0; i < 11; i++) run_txn(i, vecs[i]);

      // Watchdog: read data never returns
      cfg_withhold = 1'b1; cfg_lat = 1; cfg_wait = 0;
      @(negedge clk); #2;
      i_channel = CH_AD; i_src_addr = 11'h000; i_bytes = 10'd16; i_dst_addr = 8'h50;
      i_start = 1'b1;
      @(negedge clk); #2;
      i_start = 1'b0;
      cyc = 0; got = 1'b0;
`ifdef NTS_RX_FETCH_TIMEOUT_EN
      while (cyc < TB_TIMEOUT + 50 && !got) begin
         @(negedge clk); #2;
         cyc++;
         if (o_done) got = 1'b1;
      end
      check("wd.done", 64'(got), 64'd1);
      check("wd.error", 64'(o_error), 64'd1);
      check("wd.not_early", 64'(cyc >= TB_TIMEOUT), 64'd1);
      check("wd.len", 64'(o_len), 64'(len_exp));
`else
      while (cyc < 400) begin
         @(negedge clk); #2;
         cyc++;
         if (o_done) got = 1'b1;
      end
      check("wd.no_done", 64'(got), 64'd0);
      check("wd.busy", 64'(o_busy), 64'd1);
`endif
      i_areset = 1'b1;
      @(negedge clk); #2;
      i_areset = 1'b0;
      cfg_withhold = 1'b0;
      len_exp = '0;
      @(negedge clk); #2;

      // Reset in the middle of a long copy
      @(negedge clk); #2;
      i_channel = CH_AD; i_src_addr = 11'h080; i_bytes = 10'd188; i_dst_addr = 8'h60;
      i_start = 1'b1;
      @(negedge clk); #2;
      i_start = 1'b0;
      repeat (30) @(negedge clk);
      #2;
      check("mid.busy_before", 64'(o_busy), 64'd1);
      i_areset = 1'b1;
      #1;
      check("mid.busy", 64'(o_busy), 64'd0);
      check("mid.done", 64'(o_done), 64'd0);
      check("mid.rd_en", 64'(o_rx_rd_en), 64'd0);
      check("mid.ram_we", 64'(o_ram_we), 64'd0);
      check("mid.ram_addr", 64'(o_ram_addr), 64'd0);
      check("mid.ram_wdata", 64'(o_ram_wdata[127:64] | o_ram_wdata[63:0]), 64'd0);
      check("mid.rx_addr", 64'(o_rx_addr), 64'd0);
      check("mid.len", 64'(o_len), 64'd0);
      @(negedge clk); #2;
      i_areset = 1'b0;
      run_txn(20, '{CH_NONCE, 'h200, 16, 'h70, 0, 1, 0, 2, 1, 0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
